nileswan_bank_mapper: RTL and testbench



---
 rtl/nileswan_bank_mapper.sv | 173 +++++++++++++++++
 tb/tb_nileswan_bank_mapper.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nileswan_bank_mapper.sv
// nileswan_bank_mapper: FastClk-domain WonderSwan bank registers, write capture and memory selects; NILESWAN_MAPPER_LOCK_EN adds the E5 lock.
module nileswan_bank_mapper #(
    parameter int EXT_WIDTH   = 6,
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic                 FastClk,
    input  logic                 Reset,
    input  logic                 nSel,
    input  logic                 nIO,
    input  logic                 nOE,
    input  logic                 nWE,
    input  logic [7:0]           AddrLo,
    input  logic [3:0]           AddrHi,
    input  logic [7:0]           DataIn,
    output logic [7:0]           RegReadData,
    output logic                 RegAck,
    output logic [EXT_WIDTH-1:0] AddrExt,
    output logic                 nPSRAMSel,
    output logic                 BootromSel,
    output logic [7:0]           PSRAMUpper,
    output logic                 WritePulse,
    output logic [7:0]           WriteAddr,
    output logic [7:0]           WriteData
);
    localparam int CW = $clog2(MIN_LOW + 1);

    logic [SYNC_STAGES-1:0] sel_sync, io_sync, oe_sync, we_sync;
    logic                   sel_s, io_s, we_s, we_prev;
    logic                   capture, rise, accept, commit;
    logic [CW-1:0]          low_cnt;
    logic [7:0]             reg_addr, sh_addr, sh_data;
    logic [7:0]             linear, ram, rom0, rom1, psram_upper;
    logic [EXT_WIDTH-1:0]   bank_mask, bank;
    logic                   self_flash, enable_bootrom, any_rom;
    logic [7:0]             rd_data;
    logic                   rd_ack;
    logic                   unused;

    assign unused   = ^{oe_sync, AddrLo[7:4]};
    assign reg_addr = {AddrHi, AddrLo[3:0]};
    assign sel_s    = sel_sync[SYNC_STAGES-1];
    assign io_s     = io_sync[SYNC_STAGES-1];
    assign we_s     = we_sync[SYNC_STAGES-1];
    assign capture  = ~sel_s & ~io_s & ~we_s;
    assign rise     = we_s & ~we_prev;
    assign accept   = rise && (low_cnt >= CW'(MIN_LOW));

`ifdef NILESWAN_MAPPER_LOCK_EN
    logic locked;
    // Locked writes to E2/E4 vanish entirely, including their pulse.
    assign commit = accept & ~(locked & (sh_addr == 8'hE2 || sh_addr == 8'hE4));
`else
    assign commit = accept;
`endif

    always_ff @(posedge FastClk) begin
        if (Reset) begin
            sel_sync <= '1;
            io_sync  <= '1;
            oe_sync  <= '1;
            we_sync  <= '1;
            we_prev  <= 1'b1;
            low_cnt  <= '0;
            sh_addr  <= '0;
            sh_data  <= '0;
        end else begin
            sel_sync <= {sel_sync[SYNC_STAGES-2:0], nSel};
            io_sync  <= {io_sync[SYNC_STAGES-2:0], nIO};
            oe_sync  <= {oe_sync[SYNC_STAGES-2:0], nOE};
            we_sync  <= {we_sync[SYNC_STAGES-2:0], nWE};
            we_prev  <= we_s;
            if (rise)
                low_cnt <= '0;
            else if (capture) begin
                sh_addr <= reg_addr;
                sh_data <= DataIn;
                if (low_cnt != CW'(MIN_LOW))
                    low_cnt <= low_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge FastClk) begin
        if (Reset) begin
            linear         <= 8'hFF;
            ram            <= 8'hFF;
            rom0           <= 8'hFF;
            rom1           <= 8'hFF;
            self_flash     <= 1'b0;
            enable_bootrom <= 1'b1;
            psram_upper    <= 8'h00;
            bank_mask      <= '1;
            WritePulse     <= 1'b0;
            WriteAddr      <= 8'h00;
            WriteData      <= 8'h00;
            RegReadData    <= 8'h00;
            RegAck         <= 1'b0;
`ifdef NILESWAN_MAPPER_LOCK_EN
            locked         <= 1'b0;
`endif
        end else begin
            WritePulse  <= commit;
            RegReadData <= rd_data;
            RegAck      <= rd_ack;
            if (commit) begin
                WriteAddr <= sh_addr;
                WriteData <= sh_data;
                case (sh_addr)
                    8'hC0: linear         <= sh_data;
                    8'hC1: ram            <= sh_data;
                    8'hC2: rom0           <= sh_data;
                    8'hC3: rom1           <= sh_data;
                    8'hCE: self_flash     <= sh_data[0];
                    8'hE2: enable_bootrom <= sh_data[0];
                    8'hE3: psram_upper    <= sh_data;
                    8'hE4: bank_mask      <= sh_data[EXT_WIDTH-1:0];
`ifdef NILESWAN_MAPPER_LOCK_EN
                    8'hE5: if (sh_data[0]) locked <= 1'b1;
`endif
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_data = 8'h00;
        rd_ack  = 1'b1;
        case (reg_addr)
            8'hC0: rd_data = linear;
            8'hC1: rd_data = ram;
            8'hC2: rd_data = rom0;
            8'hC3: rd_data = rom1;
            8'hCE: rd_data = {7'b0, self_flash};
            8'hE2: rd_data = {7'b0, enable_bootrom};
            8'hE3: rd_data = psram_upper;
`ifdef NILESWAN_MAPPER_LOCK_EN
            8'hE5: rd_data = {7'b0, locked};
`endif
            default: rd_ack = 1'b0;
        endcase
    end

    always_comb begin
        bank    = '0;
        any_rom = 1'b0;
        case (AddrHi)
            4'h0: ;
            4'h1: begin
                bank    = ram[EXT_WIDTH-1:0];
                any_rom = self_flash;
            end
            4'h2: begin
                bank    = rom0[EXT_WIDTH-1:0];
                any_rom = 1'b1;
            end
            4'h3: begin
                bank    = rom1[EXT_WIDTH-1:0];
                any_rom = 1'b1;
            end
            default: begin
                bank    = {linear[EXT_WIDTH-5:0], AddrHi};
                any_rom = 1'b1;
            end
        endcase
    end

    assign AddrExt    = bank & bank_mask;
    assign BootromSel = any_rom & enable_bootrom & (&AddrExt);
    assign nPSRAMSel  = ~(~nSel & nIO & any_rom & ~BootromSel);
    assign PSRAMUpper = psram_upper;
endmodule

// File: tb/tb_nileswan_bank_mapper.sv
// tb_nileswan_bank_mapper: scoreboarded checks of nileswan_bank_mapper register writes, reads and memory mapping.
module tb_nileswan_bank_mapper;
    localparam int SYNC = 2;

    logic       FastClk = 1'b0, Reset = 1'b1;
    logic       nSel = 1'b1, nIO = 1'b1, nOE = 1'b1, nWE = 1'b1;
    logic [7:0] AddrLo = 8'h00, DataIn = 8'h00;
    logic [3:0] AddrHi = 4'h0;
    logic [7:0] RegReadData, PSRAMUpper, WriteAddr, WriteData;
    logic [5:0] AddrExt;
    logic       RegAck, nPSRAMSel, BootromSel, WritePulse;

    int          n_checks = 0, n_fail = 0;
    logic [15:0] exp_q[$];

    nileswan_bank_mapper #(.EXT_WIDTH(6), .SYNC_STAGES(SYNC), .MIN_LOW(2)) dut (
        .FastClk(FastClk), .Reset(Reset), .nSel(nSel), .nIO(nIO), .nOE(nOE), .nWE(nWE),
        .AddrLo(AddrLo), .AddrHi(AddrHi), .DataIn(DataIn),
        .RegReadData(RegReadData), .RegAck(RegAck), .AddrExt(AddrExt),
        .nPSRAMSel(nPSRAMSel), .BootromSel(BootromSel), .PSRAMUpper(PSRAMUpper),
        .WritePulse(WritePulse), .WriteAddr(WriteAddr), .WriteData(WriteData)
    );

    always #5 FastClk = ~FastClk;

    initial begin
        #500000;
        $display("FAIL timeout: run did not finish");
        $fatal(1, "timeout");
    end

    always @(negedge FastClk) begin
        if (WritePulse) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL write_pulse unexpected addr=%h data=%h", WriteAddr, WriteData);
            end else begin
                logic [15:0] e;
                e = exp_q.pop_front();
                if ({WriteAddr, WriteData} !== e) begin
                    n_fail++;
                    $display("FAIL write_pulse got addr=%h data=%h expected addr=%h data=%h",
                             WriteAddr, WriteData, e[15:8], e[7:0]);
                end
            end
        end
    end

    task automatic io_write(input logic [7:0] a, input logic [7:0] d, input int low, input bit exp);
        if (exp) exp_q.push_back({a, d});
        AddrHi = a[7:4];
        AddrLo = {4'h0, a[3:0]};
        DataIn = d;
        nSel = 1'b0;
        nIO = 1'b0;
        @(negedge FastClk);
        nWE = 1'b0;
        repeat (low) @(negedge FastClk);
        nWE = 1'b1;
        repeat (SYNC + 3) @(negedge FastClk);
        nSel = 1'b1;
        nIO = 1'b1;
        @(negedge FastClk);
    endtask

    task automatic set_addr(input logic [7:0] a);
        AddrHi = a[7:4];
        AddrLo = {4'h0, a[3:0]};
        @(negedge FastClk);
    endtask

    task automatic set_mem(input logic [3:0] hi);
        AddrHi = hi;
        AddrLo = 8'h00;
        nSel = 1'b0;
        nIO = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] ra [8];
        logic [8:0] re [8];
        ra = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hCE, 8'hE2, 8'hE3, 8'hE4};
        re = '{9'h1FF, 9'h1FF, 9'h1FF, 9'h1FF, 9'h100, 9'h101, 9'h100, 9'h000};
        Reset = 1'b1;
        repeat (3) @(negedge FastClk);
        n_checks++;
        if ({WritePulse, RegAck, RegReadData} !== 10'h000) begin
            n_fail++;
            $display("FAIL reset_outputs got pulse=%b ack=%b data=%h expected 0 0 00", WritePulse, RegAck, RegReadData);
        end
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            set_addr(ra[i]);
            n_checks++;
            if ({RegAck, RegReadData} !== re[i]) begin
                n_fail++;
                $display("FAIL reset_read_%h got ack=%b data=%h expected ack=%b data=%h",
                         ra[i], RegAck, RegReadData, re[i][8], re[i][7:0]);
            end
        end
        n_checks++;
        if (PSRAMUpper !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_psram_upper got %h expected 00", PSRAMUpper);
        end
    endtask

    task automatic test_write_commit();
        io_write(8'hC2, 8'h15, 6, 1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL commit_pulse_missing pending=%0d expected 0", exp_q.size());
        end
        set_mem(4'h2);
        n_checks++;
        if ({AddrExt, BootromSel, nPSRAMSel} !== {6'h15, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL commit_map got ext=%h boot=%b nps=%b expected 15 0 0", AddrExt, BootromSel, nPSRAMSel);
        end
        nSel = 1'b1;
        set_addr(8'hC2);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h115) begin
            n_fail++;
            $display("FAIL commit_read got ack=%b data=%h expected 1 15", RegAck, RegReadData);
        end
    endtask

    task automatic test_short_pulse();
        io_write(8'hC1, 8'h00, 1, 1'b0);
        set_addr(8'hC1);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL short_read got ack=%b data=%h expected 1 ff", RegAck, RegReadData);
        end
    endtask

    task automatic test_bootrom();
        logic [3:0] hi [4];
        logic [7:0] ex [4];
        hi = '{4'h4, 4'hF, 4'h0, 4'h1};
        ex = '{{6'h34, 2'b00}, {6'h3F, 2'b11}, {6'h00, 2'b01}, {6'h3F, 2'b01}};
        for (int i = 0; i < 4; i++) begin
            set_mem(hi[i]);
            n_checks++;
            if ({AddrExt, BootromSel, nPSRAMSel} !== ex[i]) begin
                n_fail++;
                $display("FAIL map_hi%h got ext=%h boot=%b nps=%b expected ext=%h boot=%b nps=%b",
                         hi[i], AddrExt, BootromSel, nPSRAMSel, ex[i][7:2], ex[i][1], ex[i][0]);
            end
        end
        nSel = 1'b1;
        io_write(8'hE2, 8'h00, 6, 1'b1);
        set_mem(4'hF);
        n_checks++;
        if ({AddrExt, BootromSel, nPSRAMSel} !== {6'h3F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL bootrom_off got ext=%h boot=%b nps=%b expected 3f 0 0", AddrExt, BootromSel, nPSRAMSel);
        end
        nSel = 1'b1;
        io_write(8'hE4, 8'h0F, 6, 1'b1);
        io_write(8'hC0, 8'hFF, 6, 1'b1);
        io_write(8'hE0, 8'hA5, 6, 1'b1);
        set_mem(4'h7);
        n_checks++;
        if (AddrExt !== 6'h07) begin
            n_fail++;
            $display("FAIL mask_linear got ext=%h expected 07", AddrExt);
        end
        nSel = 1'b1;
        io_write(8'hCE, 8'h01, 6, 1'b1);
        set_mem(4'h1);
        n_checks++;
        if ({AddrExt, BootromSel, nPSRAMSel} !== {6'h0F, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL self_flash got ext=%h boot=%b nps=%b expected 0f 0 0", AddrExt, BootromSel, nPSRAMSel);
        end
        nSel = 1'b1;
        set_addr(8'hE4);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h000) begin
            n_fail++;
            $display("FAIL e4_writeonly got ack=%b data=%h expected 0 00", RegAck, RegReadData);
        end
    endtask

    task automatic test_psram_upper();
        io_write(8'hE3, 8'h5A, 6, 1'b1);
        set_addr(8'hE3);
        n_checks++;
        if ({PSRAMUpper, RegAck, RegReadData} !== {8'h5A, 1'b1, 8'h5A}) begin
            n_fail++;
            $display("FAIL psram_upper got out=%h ack=%b data=%h expected 5a 1 5a", PSRAMUpper, RegAck, RegReadData);
        end
    endtask

    task automatic test_strobe_release();
        exp_q.push_back({8'hC3, 8'h2A});
        AddrHi = 4'hC;
        AddrLo = 8'h03;
        DataIn = 8'h2A;
        nSel = 1'b0;
        nIO = 1'b0;
        @(negedge FastClk);
        nWE = 1'b0;
        repeat (4) @(negedge FastClk);
        nSel = 1'b1;
        nIO = 1'b1;
        repeat (SYNC + 1) @(negedge FastClk);
        DataIn = 8'hEE;
        AddrLo = 8'h01;
        repeat (2) @(negedge FastClk);
        nWE = 1'b1;
        repeat (SYNC + 4) @(negedge FastClk);
        set_addr(8'hC3);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h12A) begin
            n_fail++;
            $display("FAIL strobe_release got ack=%b data=%h expected 1 2a", RegAck, RegReadData);
        end
    endtask

    task automatic test_back_to_back();
        exp_q.push_back({8'hC1, 8'h11});
        exp_q.push_back({8'hC2, 8'h22});
        AddrHi = 4'hC;
        AddrLo = 8'h01;
        DataIn = 8'h11;
        nSel = 1'b0;
        nIO = 1'b0;
        @(negedge FastClk);
        nWE = 1'b0;
        repeat (4) @(negedge FastClk);
        nWE = 1'b1;
        @(negedge FastClk);
        nWE = 1'b0;
        repeat (SYNC) @(negedge FastClk);
        AddrLo = 8'h02;
        DataIn = 8'h22;
        repeat (4) @(negedge FastClk);
        nWE = 1'b1;
        repeat (SYNC + 3) @(negedge FastClk);
        nSel = 1'b1;
        nIO = 1'b1;
        @(negedge FastClk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL back_to_back pending=%0d expected 0", exp_q.size());
        end
        set_addr(8'hC1);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h111) begin
            n_fail++;
            $display("FAIL back_to_back_c1 got ack=%b data=%h expected 1 11", RegAck, RegReadData);
        end
    endtask

    task automatic test_reset_release();
        int k [2];
        k = '{1, 3};
        for (int i = 0; i < 2; i++) begin
            if (k[i] >= 2) exp_q.push_back({8'hC1, 8'h44});
            AddrHi = 4'hC;
            AddrLo = 8'h01;
            DataIn = 8'h44;
            nSel = 1'b0;
            nIO = 1'b0;
            nWE = 1'b0;
            Reset = 1'b1;
            repeat (4) @(negedge FastClk);
            Reset = 1'b0;
            repeat (k[i]) @(negedge FastClk);
            nWE = 1'b1;
            repeat (SYNC + 3) @(negedge FastClk);
            nSel = 1'b1;
            nIO = 1'b1;
            set_addr(8'hC1);
            n_checks++;
            if ({RegAck, RegReadData} !== (k[i] >= 2 ? 9'h144 : 9'h1FF)) begin
                n_fail++;
                $display("FAIL reset_release_k%0d got ack=%b data=%h", k[i], RegAck, RegReadData);
            end
        end
    endtask

    task automatic test_reset_in_commit();
        AddrHi = 4'hC;
        AddrLo = 8'h02;
        DataIn = 8'h77;
        nSel = 1'b0;
        nIO = 1'b0;
        @(negedge FastClk);
        nWE = 1'b0;
        repeat (6) @(negedge FastClk);
        nWE = 1'b1;
        repeat (SYNC) @(negedge FastClk);
        Reset = 1'b1;
        @(negedge FastClk);
        Reset = 1'b0;
        repeat (4) @(negedge FastClk);
        nSel = 1'b1;
        nIO = 1'b1;
        set_addr(8'hC2);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h1FF) begin
            n_fail++;
            $display("FAIL reset_in_commit got ack=%b data=%h expected 1 ff", RegAck, RegReadData);
        end
    endtask

`ifdef NILESWAN_MAPPER_LOCK_EN
    task automatic test_lock();
        io_write(8'hE5, 8'h01, 6, 1'b1);
        io_write(8'hE2, 8'h00, 6, 1'b0);
        io_write(8'hE4, 8'h00, 6, 1'b0);
        set_addr(8'hE2);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h101) begin
            n_fail++;
            $display("FAIL lock_e2 got ack=%b data=%h expected 1 01", RegAck, RegReadData);
        end
        set_addr(8'hE5);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h101) begin
            n_fail++;
            $display("FAIL lock_e5 got ack=%b data=%h expected 1 01", RegAck, RegReadData);
        end
        set_mem(4'hF);
        n_checks++;
        if (AddrExt !== 6'h3F) begin
            n_fail++;
            $display("FAIL lock_mask got ext=%h expected 3f", AddrExt);
        end
        nSel = 1'b1;
        Reset = 1'b1;
        repeat (2) @(negedge FastClk);
        Reset = 1'b0;
        set_addr(8'hE5);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h100) begin
            n_fail++;
            $display("FAIL lock_reset got ack=%b data=%h expected 1 00", RegAck, RegReadData);
        end
    endtask
`else
    task automatic test_lock();
        io_write(8'hE5, 8'h01, 6, 1'b1);
        set_addr(8'hE5);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h000) begin
            n_fail++;
            $display("FAIL e5_unowned got ack=%b data=%h expected 0 00", RegAck, RegReadData);
        end
        io_write(8'hE2, 8'h00, 6, 1'b1);
        set_addr(8'hE2);
        n_checks++;
        if ({RegAck, RegReadData} !== 9'h100) begin
            n_fail++;
            $display("FAIL e2_writable got ack=%b data=%h expected 1 00", RegAck, RegReadData);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_commit();
        test_short_pulse();
        test_bootrom();
        test_psram_upper();
        test_strobe_release();
        test_back_to_back();
        test_reset_release();
        test_reset_in_commit();
        test_lock();
        repeat (4) @(negedge FastClk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pulses_outstanding pending=%0d expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
